// File: rtl/ifu_inst_buf_if.sv
// rtl/ifu_inst_buf_if.sv - fetch/decode side signal bundle for the instruction buffer
interface ifu_inst_buf_if #(
    parameter int DEPTH  = 4,
    parameter int INST_W = 32,
    parameter int ADDR_W = 32
);
    logic                       fetch_valid_i;
    logic                       fetch_ready_o;
    logic [INST_W-1:0]          fetch_inst_i;
    logic [ADDR_W-1:0]          fetch_addr_i;
    logic                       fetch_pred_branch_i;
    logic                       flush_i;
    logic                       stall_i;
    logic [INST_W-1:0]          inst_o;
    logic [ADDR_W-1:0]          inst_addr_o;
    logic                       is_pred_branch_o;
    logic                       inst_valid_o;
    logic [$clog2(DEPTH):0]     count_o;

    // master is the buffer itself; slave is whatever surrounds it
    modport master (
        input  fetch_valid_i, fetch_inst_i, fetch_addr_i, fetch_pred_branch_i,
        input  flush_i, stall_i,
        output fetch_ready_o, inst_o, inst_addr_o, is_pred_branch_o, inst_valid_o, count_o
    );

    modport slave (
        output fetch_valid_i, fetch_inst_i, fetch_addr_i, fetch_pred_branch_i,
        output flush_i, stall_i,
        input  fetch_ready_o, inst_o, inst_addr_o, is_pred_branch_o, inst_valid_o, count_o
    );
endinterface

// File: rtl/ifu_inst_buf.sv
// rtl/ifu_inst_buf.sv - circular instruction FIFO between fetch and decode, NOP when empty
module ifu_inst_buf #(
    parameter int                DEPTH    = 4,
    parameter int                INST_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = 32'h00000013
) (
    input  logic           clk,
    input  logic           rst,
    ifu_inst_buf_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [INST_W-1:0] mem_inst [DEPTH];
    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic              mem_pred [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic             not_empty;

    // ready is purely registered: a full buffer popping this cycle still refuses the push
    assign bus.fetch_ready_o = (count != FULL_CNT);
    assign not_empty         = (count != '0);
    assign push = bus.fetch_valid_i && bus.fetch_ready_o && !bus.flush_i;
    assign pop  = not_empty && !bus.stall_i && !bus.flush_i;

    assign bus.inst_valid_o     = not_empty;
    assign bus.inst_o           = not_empty ? mem_inst[rd_ptr] : NOP_INST;
    assign bus.inst_addr_o      = not_empty ? mem_addr[rd_ptr] : '0;
    assign bus.is_pred_branch_o = not_empty ? mem_pred[rd_ptr] : 1'b0;
    assign bus.count_o          = count;

    // storage carries no reset; occupancy alone decides what is visible
    always_ff @(posedge clk) begin
        if (push) begin
            mem_inst[wr_ptr] <= bus.fetch_inst_i;
            mem_addr[wr_ptr] <= bus.fetch_addr_i;
            mem_pred[wr_ptr] <= bus.fetch_pred_branch_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (rst) count <= FULL_CNT);
    a_ptr_match:   assert property (@(posedge clk) disable iff (rst)
                                    PTR_W'(wr_ptr - rd_ptr) == count[PTR_W-1:0]);
endmodule

// File: tb/tb_ifu_inst_buf.sv
// tb/tb_ifu_inst_buf.sv - directed self-checking bench for ifu_inst_buf
module tb_ifu_inst_buf;
    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h00000013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    ifu_inst_buf_if #(.DEPTH(DEPTH), .INST_W(32), .ADDR_W(32)) bus ();

    ifu_inst_buf #(.DEPTH(DEPTH), .INST_W(32), .ADDR_W(32), .NOP_INST(NOP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hA5C3_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic p);
        bus.fetch_valid_i       = v;
        bus.fetch_addr_i        = a;
        bus.fetch_inst_i        = inst_of(a);
        bus.fetch_pred_branch_i = p;
    endtask

    task automatic check_empty(input string tag);
        check({tag, "_inst"},  bus.inst_o, NOP);
        check({tag, "_addr"},  bus.inst_addr_o, 32'h0);
        check({tag, "_pred"},  32'(bus.is_pred_branch_o), 32'h0);
        check({tag, "_valid"}, 32'(bus.inst_valid_o), 32'h0);
        check({tag, "_ready"}, 32'(bus.fetch_ready_o), 32'h1);
        check({tag, "_count"}, 32'(bus.count_o), 32'h0);
    endtask

    task automatic check_head(input string tag, input logic [31:0] a, input logic p);
        check({tag, "_valid"}, 32'(bus.inst_valid_o), 32'h1);
        check({tag, "_addr"},  bus.inst_addr_o, a);
        check({tag, "_inst"},  bus.inst_o, inst_of(a));
        check({tag, "_pred"},  32'(bus.is_pred_branch_o), 32'(p));
    endtask

    initial begin
        bus.flush_i = 1'b0;
        bus.stall_i = 1'b0;
        drive(1'b1, 32'h8000_0000, 1'b0);

        // reset held for 3 cycles with fetch_valid_i high
        for (int i = 0; i < 3; i++) begin
            step();
            check_empty("reset");
        end
        rst = 1'b0;

        // fill under stall
        bus.stall_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h8000_0000 + 32'(4 * i), i == 2);
            step();
            check("fill_count", 32'(bus.count_o), 32'(i + 1));
            check_head("fill_head", 32'h8000_0000, 1'b0);
        end
        check("full_ready", 32'(bus.fetch_ready_o), 32'h0);
        drive(1'b1, 32'h8000_0010, 1'b0);
        step();
        check("fifth_count", 32'(bus.count_o), 32'h4);
        check("fifth_ready", 32'(bus.fetch_ready_o), 32'h0);

        // release stall and drain
        drive(1'b0, 32'h0, 1'b0);
        bus.stall_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_head("drain", 32'h8000_0000 + 32'(4 * i), i == 2);
            step();
        end
        check_empty("drained");

        // streaming at occupancy 2 across pointer wraps
        bus.stall_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i), 1'b0);
            step();
        end
        check("stream_pre_count", 32'(bus.count_o), 32'h2);
        bus.stall_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h108 + 32'(4 * i), 1'b0);
            check("stream_head", bus.inst_addr_o, 32'h100 + 32'(4 * i));
            step();
            check("stream_count", 32'(bus.count_o), 32'h2);
        end
        drive(1'b0, 32'h0, 1'b0);
        check_head("stream_tail0", 32'h128, 1'b0);
        step();
        check_head("stream_tail1", 32'h12C, 1'b0);
        step();
        check_empty("stream_done");

        // full-plus-pop bubble
        bus.stall_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h200 + 32'(4 * i), 1'b0);
            step();
        end
        check("bubble_full", 32'(bus.count_o), 32'h4);
        bus.stall_i = 1'b0;
        drive(1'b1, 32'h210, 1'b0);
        check("bubble_ready0", 32'(bus.fetch_ready_o), 32'h0);
        step();
        check("bubble_count1", 32'(bus.count_o), 32'h3);
        check("bubble_ready1", 32'(bus.fetch_ready_o), 32'h1);
        check_head("bubble_head1", 32'h204, 1'b0);
        step();
        check("bubble_count2", 32'(bus.count_o), 32'h3);
        check_head("bubble_head2", 32'h208, 1'b0);

        // flush at count 3 with a concurrent push
        bus.flush_i = 1'b1;
        drive(1'b1, 32'h214, 1'b1);
        step();
        bus.flush_i = 1'b0;
        check_empty("flush");
        drive(1'b1, 32'h218, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0);
        check("post_flush_count", 32'(bus.count_o), 32'h1);
        check_head("post_flush", 32'h218, 1'b0);
        step();
        check_empty("post_flush_drain");

        // asynchronous reset mid-stream
        bus.stall_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h300 + 32'(4 * i), 1'b0);
            step();
        end
        drive(1'b0, 32'h0, 1'b0);
        check("prerst_count", 32'(bus.count_o), 32'h2);
        #3;
        rst = 1'b1;
        #1;
        check_empty("async_rst");
        step();
        check_empty("rst_held");
        rst = 1'b0;
        drive(1'b1, 32'h400, 1'b1);
        step();
        drive(1'b0, 32'h0, 1'b0);
        check("after_rst_count", 32'(bus.count_o), 32'h1);
        check_head("after_rst", 32'h400, 1'b1);
        bus.stall_i = 1'b0;
        step();
        check_empty("after_rst_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
